// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the N-digit BCD counter.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // Width needed to hold 10**digits - 1 in binary.
    function automatic int bin_width(input int digits);
        longint p;
        int w;
        p = 1;
        w = 0;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        while ((longint'(1) << w) < p) begin
            w++;
        end
        return w;
    endfunction

    // Convert up to eight packed BCD digits into a binary value.
    function automatic logic [31:0] bcd_to_bin(input logic [31:0] bcd, input int digits);
        logic [31:0] acc;
        acc = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < digits) begin
                acc = acc * 32'd10 + {28'd0, bcd[i*4 +: 4]};
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One decimal digit of the counter: loadable, wraps 9->0 up and 0->9 down.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 up,
    input  logic                 load,
    input  logic [DIGIT_W-1:0]   ld_val,
    output logic [DIGIT_W-1:0]   q,
    output logic                 tc_up,
    output logic                 tc_dn,
    output logic                 err
);

    logic [DIGIT_W-1:0] q_d;
    logic [DIGIT_W-1:0] q_q;

    // Next digit value: load wins over stepping; invalid presets become 0.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (ld_val > DIGIT_MAX) ? '0 : ld_val;
        end else if (en) begin
            if (up) begin
                q_d = (q_q == DIGIT_MAX) ? '0 : q_q + 4'd1;
            end else begin
                q_d = (q_q == '0) ? DIGIT_MAX : q_q - 4'd1;
            end
        end
    end

    // Digit register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign tc_up = (q_q == DIGIT_MAX);
    assign tc_dn = (q_q == '0);
    assign err   = load & (ld_val > DIGIT_MAX);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with parallel load and cascade carry.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = bin_width(DIGITS)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     x,
    input  logic                     up,
    input  logic                     load,
    input  logic [4*DIGITS-1:0]      load_val,
    output logic [4*DIGITS-1:0]      bcd_out,
    output logic [BIN_W-1:0]         bin_out,
    output logic                     carry_out,
    output logic                     load_err
);

    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   tc_up;
    logic [DIGITS-1:0]   tc_dn;
    logic [DIGITS-1:0]   dig_err;
    logic [4*DIGITS-1:0] count;
    logic                load_err_d;
    logic                load_err_q;

    // Ripple enable: a digit steps only when every lower digit is at its terminal value.
    always_comb begin
        en    = '0;
        en[0] = x;
        for (int i = 1; i < DIGITS; i++) begin
            en[i] = en[i-1] & (up ? tc_up[i-1] : tc_dn[i-1]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .en     (en[g]),
            .up     (up),
            .load   (load),
            .ld_val (load_val[g*4 +: 4]),
            .q      (count[g*4 +: 4]),
            .tc_up  (tc_up[g]),
            .tc_dn  (tc_dn[g]),
            .err    (dig_err[g])
        );
    end

    // Flag a load that carried any out-of-range nibble.
    always_comb begin
        load_err_d = load & (|dig_err);
    end

    // One-cycle registered load error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign bcd_out   = count;
    assign bin_out   = BIN_W'(bcd_to_bin(32'(count), DIGITS));
    assign carry_out = x & ~load & (up ? (&tc_up) : (&tc_dn));
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n at DIGITS = 2, 3 and a cascaded pair of 4.
module tb_bcd_counter_n;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] exp_bcd;
        logic [31:0] exp_bin;
        logic        exp_err;
        logic [31:0] exp_hi;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        x2 = 0, up2 = 0, load2 = 0;
    logic [7:0]  lv2 = '0;
    logic [7:0]  bcd2;
    logic [6:0]  bin2;
    logic        carry2, err2;

    logic        x3 = 0, up3 = 0, load3 = 0;
    logic [11:0] lv3 = '0;
    logic [11:0] bcd3;
    logic [9:0]  bin3;
    logic        carry3, err3;

    logic        xc = 0, upc = 0, loadc = 0;
    logic [31:0] lvc = '0;
    logic [15:0] bcd_lo, bcd_hi;
    logic [13:0] bin_lo, bin_hi;
    logic        carry_lo, carry_hi, err_lo, err_hi;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    int m2 = 0, m3 = 0, mlo = 0, mhi = 0;
    logic e2 = 0, e3 = 0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .x(x2), .up(up2), .load(load2), .load_val(lv2),
        .bcd_out(bcd2), .bin_out(bin2), .carry_out(carry2), .load_err(err2));

    bcd_counter_n #(.DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .x(x3), .up(up3), .load(load3), .load_val(lv3),
        .bcd_out(bcd3), .bin_out(bin3), .carry_out(carry3), .load_err(err3));

    bcd_counter_n #(.DIGITS(4)) dut_lo (
        .clk(clk), .reset(reset), .x(xc), .up(upc), .load(loadc), .load_val(lvc[15:0]),
        .bcd_out(bcd_lo), .bin_out(bin_lo), .carry_out(carry_lo), .load_err(err_lo));

    bcd_counter_n #(.DIGITS(4)) dut_hi (
        .clk(clk), .reset(reset), .x(carry_lo), .up(upc), .load(loadc), .load_val(lvc[31:16]),
        .bcd_out(bcd_hi), .bin_out(bin_hi), .carry_out(carry_hi), .load_err(err_hi));

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        int t = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clean_val(input logic [31:0] ldv, input int n);
        int r = 0;
        logic [3:0] nib;
        for (int i = n - 1; i >= 0; i--) begin
            nib = ldv[i*4 +: 4];
            r = r * 10 + ((nib > 4'd9) ? 0 : int'(nib));
        end
        return r;
    endfunction

    function automatic logic any_bad(input logic [31:0] ldv, input int n);
        logic b = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ldv[i*4 +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    function automatic int next_val(input int v, input int n, input logic ld,
                                    input logic [31:0] ldv, input logic xx, input logic uu);
        int mx = pow10(n) - 1;
        if (ld) return clean_val(ldv, n);
        if (xx) return uu ? ((v == mx) ? 0 : v + 1) : ((v == 0) ? mx : v - 1);
        return v;
    endfunction

    function automatic logic carry_exp(input int v, input int n, input logic xx,
                                       input logic ld, input logic uu);
        return xx & ~ld & (uu ? (v == pow10(n) - 1) : (v == 0));
    endfunction

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every queued expectation against the DUT it belongs to.
    task automatic drainQueue();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                2: begin
                    checkOutput({e.tag, "_bcd"}, 32'(bcd2), e.exp_bcd);
                    checkOutput({e.tag, "_bin"}, 32'(bin2), e.exp_bin);
                    checkOutput({e.tag, "_err"}, 32'(err2), 32'(e.exp_err));
                end
                3: begin
                    checkOutput({e.tag, "_bcd"}, 32'(bcd3), e.exp_bcd);
                    checkOutput({e.tag, "_bin"}, 32'(bin3), e.exp_bin);
                    checkOutput({e.tag, "_err"}, 32'(err3), 32'(e.exp_err));
                end
                default: begin
                    checkOutput({e.tag, "_lo"}, 32'(bcd_lo), e.exp_bcd);
                    checkOutput({e.tag, "_lobin"}, 32'(bin_lo), e.exp_bin);
                    checkOutput({e.tag, "_hi"}, 32'(bcd_hi), e.exp_hi);
                end
            endcase
        end
    endtask

    // Drive one cycle of stimulus to the selected DUT, check carry, queue the result.
    task automatic applyStimulus(input int sel, input logic rst, input logic ld,
                                 input logic [31:0] ldv, input logic xx, input logic uu,
                                 input string tag);
        exp_t e;
        logic c_lo;
        @(negedge clk);
        reset = rst;
        x2 = 0; load2 = 0; x3 = 0; load3 = 0; xc = 0; loadc = 0;
        up2 = uu; up3 = uu; upc = uu;
        lv2 = ldv[7:0]; lv3 = ldv[11:0]; lvc = ldv;
        case (sel)
            2: begin x2 = xx; load2 = ld; end
            3: begin x3 = xx; load3 = ld; end
            default: begin xc = xx; loadc = ld; end
        endcase
        #1;
        c_lo = carry_exp(mlo, 4, xx, ld, uu);
        case (sel)
            2: checkOutput({tag, "_carry"}, 32'(carry2), 32'(carry_exp(m2, 2, xx, ld, uu)));
            3: checkOutput({tag, "_carry"}, 32'(carry3), 32'(carry_exp(m3, 3, xx, ld, uu)));
            default: checkOutput({tag, "_carry"}, 32'(carry_lo), 32'(c_lo));
        endcase
        if (rst) begin
            m2 = 0; m3 = 0; mlo = 0; mhi = 0; e2 = 0; e3 = 0;
        end else begin
            e2 = 0; e3 = 0;
            case (sel)
                2: begin
                    e2 = ld & any_bad(ldv, 2);
                    m2 = next_val(m2, 2, ld, ldv, xx, uu);
                end
                3: begin
                    e3 = ld & any_bad(ldv, 3);
                    m3 = next_val(m3, 3, ld, ldv, xx, uu);
                end
                default: begin
                    mhi = next_val(mhi, 4, ld, ldv >> 16, c_lo, uu);
                    mlo = next_val(mlo, 4, ld, ldv, xx, uu);
                end
            endcase
        end
        e.sel = sel;
        e.tag = tag;
        case (sel)
            2: begin e.exp_bcd = to_bcd(m2); e.exp_bin = 32'(m2); e.exp_err = e2; end
            3: begin e.exp_bcd = to_bcd(m3); e.exp_bin = 32'(m3); e.exp_err = e3; end
            default: begin e.exp_bcd = to_bcd(mlo); e.exp_bin = 32'(mlo); e.exp_err = 1'b0; end
        endcase
        e.exp_hi = to_bcd(mhi);
        sb.push_back(e);
        @(posedge clk);
        #1;
        drainQueue();
    endtask

    // Stimulus sequence covering counting, wrap, load, error flag, priority and cascade.
    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_bcd", 32'(bcd2), 32'h0);
        checkOutput("rst_bin", 32'(bin2), 32'h0);
        checkOutput("rst_err", 32'(err2), 32'h0);

        for (int i = 0; i < 100; i++) begin
            applyStimulus(2, 0, 0, 32'h0, 1, 1, $sformatf("up%0d", i));
        end

        applyStimulus(2, 0, 1, 32'h10, 0, 1, "ld10");
        applyStimulus(2, 0, 0, 32'h0, 1, 0, "dn1");
        applyStimulus(2, 0, 0, 32'h0, 1, 0, "dn2");

        applyStimulus(2, 1, 0, 32'h0, 0, 0, "rst2");
        applyStimulus(2, 0, 0, 32'h0, 1, 0, "dnwrap");

        applyStimulus(2, 0, 1, 32'h42, 1, 1, "ldx");
        applyStimulus(2, 1, 1, 32'h42, 1, 1, "rstld");
        applyStimulus(2, 0, 1, 32'hA5, 0, 1, "ldbad");
        applyStimulus(2, 0, 0, 32'h0, 0, 1, "hold");

        applyStimulus(2, 0, 1, 32'h50, 0, 1, "ld50");
        applyStimulus(2, 0, 0, 32'h0, 1, 1, "dirup");
        applyStimulus(2, 0, 0, 32'h0, 1, 0, "dirdn1");
        applyStimulus(2, 0, 0, 32'h0, 1, 0, "dirdn2");
        applyStimulus(2, 0, 0, 32'h0, 1, 1, "dirup2");

        applyStimulus(3, 0, 1, 32'h1A7, 0, 1, "d3ldbad");
        applyStimulus(3, 0, 0, 32'h0, 0, 1, "d3hold");
        applyStimulus(3, 0, 1, 32'h456, 0, 1, "d3ldok");
        applyStimulus(3, 0, 0, 32'h0, 1, 0, "d3dn");

        applyStimulus(4, 0, 1, 32'h0000_9998, 0, 1, "cld");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4, 0, 0, 32'h0, 1, 1, $sformatf("cup%0d", i));
        end
        applyStimulus(4, 0, 0, 32'h0, 1, 0, "cdn");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
